// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM port arbiter: FSM states, requester ids and
// the per-transaction control word held between accept and response.
package ram_arb_pkg;

  localparam int DEF_DATA_W     = 64;
  localparam int DEF_ADDR_W     = 64;
  localparam int DEF_RAM_AW     = 28;
  localparam int DEF_STARVE_MAX = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  typedef struct packed {
    owner_t owner;
    logic   we;
    logic   err;
  } txn_ctl_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Fetch, data and RAM-side signals of the arbiter grouped as one bundle;
// slave is the arbiter's view, master is the core/RAM side.
interface ram_port_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
) ();

  logic              if_req_valid;
  logic              if_req_ready;
  logic [ADDR_W-1:0] if_req_addr;
  logic              if_rsp_valid;
  logic              if_rsp_ready;
  logic [DATA_W-1:0] if_rsp_data;
  logic              if_rsp_err;

  logic              d_req_valid;
  logic              d_req_ready;
  logic              d_req_we;
  logic [ADDR_W-1:0] d_req_addr;
  logic [DATA_W-1:0] d_req_wdata;
  logic              d_rsp_valid;
  logic              d_rsp_ready;
  logic [DATA_W-1:0] d_rsp_data;
  logic              d_rsp_err;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  if_req_valid, if_req_addr, if_rsp_ready,
    input  d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_rsp_ready,
    input  ram_rdata,
    output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
    output d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
    output ram_we, ram_addr, ram_wdata
  );

  modport master (
    output if_req_valid, if_req_addr, if_rsp_ready,
    output d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_rsp_ready,
    output ram_rdata,
    input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
    input  d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
    input  ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/ram_arb_prio.sv
// Winner select between fetch and data plus the fetch starvation counter.
// Data has priority until fetch has watched STARVE_MAX data grants go by.
module ram_arb_prio
  import ram_arb_pkg::*;
#(
  parameter int STARVE_MAX = DEF_STARVE_MAX,
  localparam int CNT_W = $clog2(STARVE_MAX + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_idle,
  input  logic             i_if_valid,
  input  logic             i_d_valid,
  output logic             o_if_ready,
  output logic             o_d_ready,
  output logic [CNT_W-1:0] o_starve_cnt
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_starved;
  logic             w_if_win;
  logic             w_d_win;

  assign w_starved = (r_cnt == CNT_W'(STARVE_MAX));
  assign w_if_win  = i_if_valid & (~i_d_valid | w_starved);
  assign w_d_win   = i_d_valid & ~w_if_win;

  assign o_if_ready   = i_idle & w_if_win;
  assign o_d_ready    = i_idle & w_d_win;
  assign o_starve_cnt = r_cnt;

  // Only data grants that actually made fetch wait count toward starvation.
  always_ff @(posedge clk) begin
    if (reset)
      r_cnt <= '0;
    else if (o_if_ready & i_if_valid)
      r_cnt <= '0;
    else if (o_d_ready & i_d_valid & i_if_valid & ~w_starved)
      r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port word RAM between instruction fetch and data memory:
// one transaction at a time, IDLE -> ACCESS -> RESP, registered response.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int RAM_AW     = DEF_RAM_AW,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input logic clk,
  input logic reset,
  ram_port_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  state_t            r_state;
  state_t            w_state_nxt;
  txn_ctl_t          r_ctl;
  logic [RAM_AW-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rsp_data;

  logic              w_idle;
  logic              w_access;
  logic              w_resp;
  logic              w_if_ready;
  logic              w_d_ready;
  logic              w_if_acc;
  logic              w_d_acc;
  logic [ADDR_W-1:0] w_acc_addr;
  logic              w_acc_err;
  logic              w_rsp_ready;
  logic [CNT_W-1:0]  w_starve_cnt;

  assign w_idle   = (r_state == IDLE) & ~reset;
  assign w_access = (r_state == ACCESS);
  assign w_resp   = (r_state == RESP);

  ram_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .clk          (clk),
    .reset        (reset),
    .i_idle       (w_idle),
    .i_if_valid   (bus.if_req_valid),
    .i_d_valid    (bus.d_req_valid),
    .o_if_ready   (w_if_ready),
    .o_d_ready    (w_d_ready),
    .o_starve_cnt (w_starve_cnt)
  );

  assign bus.if_req_ready = w_if_ready;
  assign bus.d_req_ready  = w_d_ready;

  assign w_if_acc   = bus.if_req_valid & w_if_ready;
  assign w_d_acc    = bus.d_req_valid & w_d_ready;
  assign w_acc_addr = w_d_acc ? bus.d_req_addr : bus.if_req_addr;
  assign w_acc_err  = |w_acc_addr[ADDR_W-1:RAM_AW];

  assign w_rsp_ready = (r_ctl.owner == OWN_D) ? bus.d_rsp_ready : bus.if_rsp_ready;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_if_acc | w_d_acc) w_state_nxt = ACCESS;
      ACCESS:  w_state_nxt = RESP;
      RESP:    if (w_rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Reset drops any in-flight transaction outright; nothing is answered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_ctl      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rsp_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_if_acc | w_d_acc) begin
        r_ctl.owner <= w_d_acc ? OWN_D : OWN_IF;
        r_ctl.we    <= w_d_acc & bus.d_req_we;
        r_ctl.err   <= w_acc_err;
        r_addr      <= w_acc_addr[RAM_AW-1:0];
        r_wdata     <= w_d_acc ? bus.d_req_wdata : '0;
      end
      if (w_access)
        r_rsp_data <= (r_ctl.we | r_ctl.err) ? '0 : bus.ram_rdata;
    end
  end

  assign bus.ram_we    = w_access & r_ctl.we & ~r_ctl.err & ~reset;
  assign bus.ram_addr  = w_access ? {{(ADDR_W-RAM_AW){1'b0}}, r_addr} : '0;
  assign bus.ram_wdata = w_access ? r_wdata : '0;

  assign bus.if_rsp_valid = w_resp & (r_ctl.owner == OWN_IF);
  assign bus.d_rsp_valid  = w_resp & (r_ctl.owner == OWN_D);
  assign bus.if_rsp_data  = bus.if_rsp_valid ? r_rsp_data : '0;
  assign bus.d_rsp_data   = bus.d_rsp_valid ? r_rsp_data : '0;
  assign bus.if_rsp_err   = bus.if_rsp_valid & r_ctl.err;
  assign bus.d_rsp_err    = bus.d_rsp_valid & r_ctl.err;

endmodule
